// File: rtl/shift_pkg.sv
// Constants and word type shared by the serial shift-register stages.
package shift_pkg;

   localparam int WIDTH_DEF = 4;
   localparam int DEPTH_DEF = 2;

   typedef logic [WIDTH_DEF-1:0] word_t;

endpackage

// File: rtl/word_fifo.sv
// Register-based word FIFO. Read data comes straight from the storage registers.
module word_fifo #(
   parameter int WIDTH = 4,
   parameter int DEPTH = 2
) (
   input  logic             clk,
   input  logic             areset_n,
   input  logic             push,
   input  logic             pop,
   input  logic [WIDTH-1:0] push_data,
   output logic [WIDTH-1:0] data,
   output logic             full,
   output logic             empty
);

   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW:0]      wr_ptr;
   logic [AW:0]      rd_ptr;
   logic             do_push;
   logic             do_pop;

   // Pointers carry one extra wrap bit so full and empty are distinguishable.
   assign empty   = (wr_ptr == rd_ptr);
   assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
   assign do_pop  = pop && !empty;
   assign do_push = push && (!full || do_pop);
   assign data    = mem[rd_ptr[AW-1:0]];

   always_ff @(posedge clk or negedge areset_n) begin
      if (!areset_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      end else begin
         if (do_push) begin
            mem[wr_ptr[AW-1:0]] <= push_data;
            wr_ptr              <= wr_ptr + 1'b1;
         end
         if (do_pop) rd_ptr <= rd_ptr + 1'b1;
      end
   end

endmodule

// File: rtl/shift_deserializer.sv
// Serial-to-parallel converter: LSB-first bits are assembled into words and queued in a FIFO.
module shift_deserializer
   import shift_pkg::*;
#(
   parameter int WIDTH = WIDTH_DEF,
   parameter int DEPTH = DEPTH_DEF
) (
   input  logic                     clk,
   input  logic                     areset_n,
   input  logic                     clr,
   input  logic                     bit_in,
   input  logic                     bit_valid,
   output logic [WIDTH-1:0]         out_data,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic [$clog2(WIDTH)-1:0] bit_cnt,
   output logic                     overflow
);

   localparam int CW = $clog2(WIDTH);

   logic [WIDTH-1:0] acc;
   logic [WIDTH-1:0] word_next;
   logic [CW-1:0]    cnt;
   logic             accept;
   logic             complete;
   logic             pop;
   logic             full;
   logic             empty;

   assign word_next = {bit_in, acc[WIDTH-1:1]};
   assign accept    = bit_valid && !clr;
   assign complete  = accept && (cnt == CW'(WIDTH - 1));
   assign out_valid = !empty;
   assign pop       = out_valid && out_ready;
   assign bit_cnt   = cnt;

   always_ff @(posedge clk or negedge areset_n) begin
      if (!areset_n) begin
         acc      <= '0;
         cnt      <= '0;
         overflow <= 1'b0;
      end else if (clr) begin
         acc      <= '0;
         cnt      <= '0;
         overflow <= 1'b0;
      end else if (accept) begin
         acc <= word_next;
         cnt <= complete ? '0 : cnt + 1'b1;
         // A same-edge pop frees a slot, so only a push into a full, non-draining FIFO drops.
         if (complete && full && !pop) overflow <= 1'b1;
      end
   end

   word_fifo #(
      .WIDTH(WIDTH),
      .DEPTH(DEPTH)
   ) u_fifo (
      .clk      (clk),
      .areset_n (areset_n),
      .push     (complete),
      .pop      (pop),
      .push_data(word_next),
      .data     (out_data),
      .full     (full),
      .empty    (empty)
   );

endmodule

// File: tb/tb_shift_deserializer.sv
// Directed bench for shift_deserializer with hand-computed expected words.
module tb_shift_deserializer;
   import shift_pkg::*;

   logic       clk;
   logic       areset_n;
   logic       clr;
   logic       bit_in;
   logic       bit_valid;
   word_t      out_data;
   logic       out_valid;
   logic       out_ready;
   logic [1:0] bit_cnt;
   logic       overflow;

   int n_vec;
   int n_err;

   shift_deserializer dut (
      .clk      (clk),
      .areset_n (areset_n),
      .clr      (clr),
      .bit_in   (bit_in),
      .bit_valid(bit_valid),
      .out_data (out_data),
      .out_valid(out_valid),
      .out_ready(out_ready),
      .bit_cnt  (bit_cnt),
      .overflow (overflow)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Inputs change on the falling edge; the next rising edge samples them.
   task automatic send_bit(input logic b);
      bit_in    = b;
      bit_valid = 1'b1;
      @(negedge clk);
      bit_valid = 1'b0;
   endtask

   task automatic send_word(input word_t w);
      for (int i = 0; i < 4; i++) send_bit(w[i]);
   endtask

   task automatic pop_check(input string tag, input word_t exp);
      check_val({tag, "_valid"}, out_valid, 1);
      check_val({tag, "_data"}, out_data, exp);
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
   endtask

   initial begin
      word_t w;
      n_vec     = 0;
      n_err     = 0;
      areset_n  = 1'b0;
      clr       = 1'b0;
      bit_in    = 1'b0;
      bit_valid = 1'b0;
      out_ready = 1'b0;
      repeat (2) @(negedge clk);
      areset_n = 1'b1;
      @(negedge clk);

      check_val("rst_valid", out_valid, 0);
      check_val("rst_cnt", bit_cnt, 0);
      check_val("rst_ovf", overflow, 0);
      check_val("rst_data", out_data, 0);

      // 1,0,1,1 -> 4'b1101, visible right after the 4th bit's edge
      send_bit(1'b1);
      send_bit(1'b0);
      send_bit(1'b1);
      check_val("b3_cnt", bit_cnt, 3);
      check_val("b3_valid", out_valid, 0);
      send_bit(1'b1);
      check_val("w1101_cnt", bit_cnt, 0);
      pop_check("w1101", 4'b1101);
      check_val("w1101_empty", out_valid, 0);

      // out_ready while empty has no effect
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
      check_val("idle_ready_valid", out_valid, 0);

      // overflow: A,5 kept, F dropped
      send_word(4'hA);
      send_word(4'h5);
      check_val("full_ovf0", overflow, 0);
      send_word(4'hF);
      check_val("drop_ovf", overflow, 1);
      pop_check("ovf_pop0", 4'hA);
      pop_check("ovf_pop1", 4'h5);
      check_val("ovf_empty", out_valid, 0);
      check_val("ovf_sticky", overflow, 1);
      clr = 1'b1;
      @(negedge clk);
      clr = 1'b0;
      check_val("clr_ovf", overflow, 0);

      // push and pop on the same edge while full
      send_word(4'h1);
      send_word(4'h2);
      w = 4'h3;
      for (int i = 0; i < 3; i++) send_bit(w[i]);
      out_ready = 1'b1;
      send_bit(w[3]);
      out_ready = 1'b0;
      check_val("pp_ovf", overflow, 0);
      pop_check("pp_pop0", 4'h2);
      pop_check("pp_pop1", 4'h3);
      check_val("pp_empty", out_valid, 0);

      // clr beats a simultaneous bit
      send_bit(1'b1);
      send_bit(1'b1);
      check_val("pre_clr_cnt", bit_cnt, 2);
      clr = 1'b1;
      send_bit(1'b1);
      clr = 1'b0;
      check_val("clr_cnt", bit_cnt, 0);
      check_val("clr_valid", out_valid, 0);
      send_word(4'h8);
      pop_check("after_clr", 4'h8);

      // async reset mid-clock with buffered words, partial word and overflow
      send_word(4'h9);
      send_word(4'h6);
      send_word(4'hC);
      send_bit(1'b1);
      send_bit(1'b0);
      send_bit(1'b1);
      check_val("pre_rst_cnt", bit_cnt, 3);
      check_val("pre_rst_ovf", overflow, 1);
      check_val("pre_rst_valid", out_valid, 1);
      #2 areset_n = 1'b0;
      #1;
      check_val("arst_valid", out_valid, 0);
      check_val("arst_cnt", bit_cnt, 0);
      check_val("arst_ovf", overflow, 0);
      check_val("arst_data", out_data, 0);
      @(negedge clk);
      areset_n = 1'b1;
      // first edge after release samples the first bit
      send_word(4'h5);
      pop_check("post_rst", 4'h5);

      // gapped bit_valid, one bit every third cycle
      w = 4'h6;
      for (int i = 0; i < 4; i++) begin
         send_bit(w[i]);
         if (i < 3) begin
            check_val("gap_cnt_a", bit_cnt, i + 1);
            @(negedge clk);
            @(negedge clk);
            check_val("gap_cnt_b", bit_cnt, i + 1);
            check_val("gap_valid", out_valid, 0);
         end
      end
      check_val("gap_cnt_end", bit_cnt, 0);
      pop_check("gap_word", 4'h6);
      check_val("gap_empty", out_valid, 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/shift_deserializer.md
SHIFT_DESERIALIZER -- requirements
Module: shift_deserializer

Interface
REQ-001 Parameter WIDTH, default 4, bits per assembled word (WIDTH >= 2).
REQ-002 Parameter DEPTH, default 2, output FIFO entries (power of two, >= 2).
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 areset_n  input  1  asynchronous, active-low reset.
REQ-005 clr  input  1  synchronous clear of partial word and overflow flag.
REQ-006 bit_in  input  1  serial data bit, LSB of each word first (the upstream right-shift register's q[0]).
REQ-007 bit_valid  input  1  bit_in sampled this cycle when high.
REQ-008 out_data  output  WIDTH  head-of-FIFO word; don't-care when out_valid low.
REQ-009 out_valid  output  1  FIFO non-empty.
REQ-010 out_ready  input  1  consumer accepts; a pop occurs when out_valid && out_ready.
REQ-011 bit_cnt  output  $clog2(WIDTH)  bits collected in the current partial word.
REQ-012 overflow  output  1  sticky; a completed word was dropped.

Function
REQ-013 Each accepted bit SHALL shift into the accumulator from the MSB end (acc <= {bit_in, acc[WIDTH-1:1]}), so the first bit received lands in out_data[0].
REQ-014 bit_cnt SHALL increment per accepted bit and wrap from WIDTH-1 to 0 on the completing bit.
REQ-015 On the completing bit, the assembled word SHALL be pushed on the same edge; out_valid rises the following cycle (latency 1 clock from the last bit's sampling edge when the FIFO was empty).
REQ-016 out_data/out_valid SHALL be driven directly from FIFO registers, with no combinational path from bit_in or bit_valid.
REQ-017 The FIFO SHALL preserve word order; a pop removes the head on the edge where out_valid && out_ready.
REQ-018 Push and pop on the same edge SHALL both take effect, including when the FIFO is full, with no loss.
REQ-019 Push while full without a simultaneous pop SHALL drop the new word, leave the FIFO contents unchanged and set overflow.
REQ-020 overflow SHALL remain set until clr or reset.
REQ-021 clr SHALL zero the accumulator, bit_cnt and overflow; FIFO contents and out_valid SHALL be unaffected.
REQ-022 clr has priority over bit_valid in the same cycle; that bit SHALL be discarded.
REQ-023 A pop in the same cycle as clr SHALL still occur.
REQ-024 With bit_valid low, accumulator and bit_cnt SHALL hold.
REQ-025 out_ready while out_valid is low SHALL have no effect.

Reset
REQ-026 areset_n low SHALL immediately force accumulator=0, bit_cnt=0, FIFO empty (out_valid=0), pointers=0, overflow=0.
REQ-027 Reset mid-word or with the FIFO occupied SHALL discard all partial and buffered data; out_data SHALL read 0 after reset.
REQ-028 The first rising edge after areset_n deasserts SHALL operate normally; no extra idle cycle.

Structure
REQ-029 Shared package shift_pkg SHALL hold the WIDTH and DEPTH default constants and a word_t typedef, shared with the upstream shift-register stage.
REQ-030 The FIFO SHALL be a separate sub-module word_fifo (push, pop, full, empty, data); the accumulator, counter and overflow logic stay in shift_deserializer.

Verification
REQ-031 Reset, then send bits 1,0,1,1 on consecutive cycles -> out_valid=1 exactly one cycle after the 4th bit; out_data=4'b1101; bit_cnt=0.
REQ-032 Out_ready held low, three words 4'hA, 4'h5, 4'hF sent -> FIFO holds A,5; F dropped; overflow=1; out_ready high then pops A, then 5; out_valid=0.
REQ-033 FIFO full with out_ready=1 on the completing-bit edge of word 4'h3 -> no drop, overflow stays 0; pops return the original order, ending with 3.
REQ-034 Two bits sent, clr asserted together with a third bit_valid -> bit_cnt=0; next four bits 0,0,0,1 yield out_data=4'h8.
REQ-035 areset_n pulsed low asynchronously, mid-clock, with 2 words buffered and bit_cnt=3 -> out_valid, bit_cnt and overflow are 0 before the next edge.
REQ-036 bit_valid gapped (1 on every third cycle) for 4 bits of 0,1,1,0 -> single word 4'h6; bit_cnt holds during gaps.
